plot_sink: RTL and testbench
============================

# plot_sink

Pixel-stream consumer for the 160x120 drawing pipeline. Accepts the same `vga_x`/`vga_y`/`vga_colour`/`vga_plot` stream that the fill-screen and Reuleaux drawers emit. Writes each plotted pixel into an internal 3-bit-per-pixel framebuffer, and on request scans the whole frame back out in raster order. It sits in place of, or beside, the VGA adapter so that benches and on-chip checkers can read back exactly what the drawers produced.

## Interface

Parameters:
- `WIDTH`, default 160: frame width in pixels.
- `HEIGHT`, default 120: frame height in pixels.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `vga_x` in 8: plot column.
- `vga_y` in 7: plot row.
- `vga_colour` in 3: plot colour.
- `vga_plot` in 1: write strobe; one pixel per cycle where high.
- `start_scan` in 1: begin a raster readback; sampled only in IDLE.
- `pix_x` out 8: column of the current readback pixel.
- `pix_y` out 7: row of the current readback pixel.
- `pix_colour` out 3: stored colour of the current readback pixel.
- `pix_valid` out 1: `pix_*` are valid this cycle.
- `scan_done` out 1: one-cycle pulse, coincident with the last `pix_valid`.
- `scanning` out 1: high while in SCAN or DRAIN.
- `plot_count` out 15: accepted plots, saturating at 32767.
- `oob_count` out 8: rejected out-of-range plots, saturating at 255.

## Operation

- Framebuffer: WIDTH*HEIGHT x 3 bits, single-port synchronous RAM. Address is `y*WIDTH + x`, 15 bits, with no wrap.
- Plot acceptance:
  - A plot is accepted when `vga_plot`=1, `vga_x` < WIDTH and `vga_y` < HEIGHT. The colour is written that cycle and `plot_count` increments.
  - Otherwise the plot is dropped, there is no write, and `oob_count` increments.
- Plot priority: a plot always owns the RAM port. There is no backpressure and no plot is ever lost.
- State machine (IDLE, SCAN, DRAIN, DONE):
  - IDLE: `start_scan`=1 moves to SCAN and zeros the raster counters `rx` and `ry`.
  - SCAN: in each cycle with `vga_plot`=0, issue a read at (`rx`,`ry`) and advance `rx`. When `rx` reaches WIDTH-1, `rx` wraps to 0 and `ry` increments. In a cycle with `vga_plot`=1 the read stalls and the counters hold. After the read at (WIDTH-1,HEIGHT-1) is issued, move to DRAIN.
  - DRAIN: one cycle to let the final read return. Then move to DONE.
  - DONE: one cycle, then IDLE.
- `start_scan` outside IDLE is ignored.
- Read/write ordering: a plot accepted in cycle N is visible to any read issued in cycle N+1 or later.
- Plots continue to be accepted in every state.

## Timing

- Reset values: state IDLE; `pix_x`=0, `pix_y`=0, `pix_colour`=0, `pix_valid`=0, `scan_done`=0, `scanning`=0, `plot_count`=0, `oob_count`=0. Framebuffer contents are undefined after reset unless the clear feature is compiled in.
- Read latency is 1 cycle: a read issued in cycle N gives `pix_valid`=1 in cycle N+1, with `pix_x`/`pix_y` equal to the address issued in N.
- Output timing:
  - `pix_valid` is registered and is low in stall cycles.
  - `scan_done` pulses high in the DRAIN cycle, together with `pix_valid` for pixel (WIDTH-1,HEIGHT-1).
- Scan length with no plots: `start_scan` in cycle 0 gives the first `pix_valid` in cycle 2 and `scan_done` in cycle WIDTH*HEIGHT+1. Each overlapping plot adds 1 cycle.
- `scanning` is high from the cycle after `start_scan` through the DRAIN cycle.
- Counter behaviour: the counters never wrap; they hold at their maximum.
- Reset mid-scan: outputs return to their reset values immediately and the state returns to IDLE. Framebuffer contents are retained.

## Configuration

- Macro `PLOT_SINK_CLEAR_EN`.
- Defined:
  - Adds an input port `clear` (1 bit) and a state CLEAR.
  - Reset exit, or `clear`=1 while in IDLE, enters CLEAR.
  - CLEAR writes colour 0 to addresses 0..WIDTH*HEIGHT-1, one per cycle, then returns to IDLE.
  - Plots arriving during CLEAR are dropped and counted in `oob_count`.
  - `scanning` stays low during CLEAR, and `start_scan` is ignored.
- Undefined: there is no `clear` port and no CLEAR state; the framebuffer power-up contents are undefined.

## Test plan

- Plot (5,7,colour 3), then a scan with no further plots: the pixel at x=5, y=7 reads colour 3; `scan_done` rises exactly at cycle 19201 after `start_scan`; `plot_count`=1.
- Plots at (160,0) and (0,120): no write, `oob_count`=2, `plot_count`=0, and the scan output is unchanged.
- During a scan, drive `vga_plot`=1 for 10 consecutive cycles at (159,119,colour 6): the read stalls 10 cycles, `scan_done` arrives at cycle 19211, and the final pixel reads colour 6.
- Full fill-screen stream (19200 plots, colour = x mod 8), then a scan: every `pix_colour` equals `pix_x` mod 8 and `plot_count`=19200.
- Assert `rst` at scan pixel 500: `pix_valid`, `scanning` and the counters are 0 immediately. A new scan returns the previously written data.
- With `PLOT_SINK_CLEAR_EN` defined: write colour 7 everywhere, pulse `clear`, wait 19200 cycles, then scan: all pixels are 0.

Source files
------------

// File: rtl/plot_sink.sv
// plot_sink: pixel-stream consumer for the 160x120 drawing pipeline.
// Stores every accepted plot in a 3-bit-per-pixel framebuffer and, on
// start_scan, streams the whole frame back out in raster order.
// Plots always own the single RAM port; a plot during a scan stalls the read.
// Optional feature: define PLOT_SINK_CLEAR_EN to add a `clear` input and a
// CLEAR state that zeroes the framebuffer after reset or on request.
module plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PLOT_SINK_CLEAR_EN
    input  logic        clear,
`endif
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        start_scan,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic [2:0]  pix_colour,
    output logic        pix_valid,
    output logic        scan_done,
    output logic        scanning,
    output logic [14:0] plot_count,
    output logic [7:0]  oob_count
);

    localparam int          NPIX   = WIDTH * HEIGHT;
    localparam logic [8:0]  X_LIM  = 9'(WIDTH);
    localparam logic [7:0]  Y_LIM  = 8'(HEIGHT);
    localparam logic [7:0]  X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0]  Y_LAST = 7'(HEIGHT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef PLOT_SINK_CLEAR_EN
    localparam logic [2:0]  S_CLEAR = 3'd4;
    localparam logic [14:0] A_LAST  = 15'(NPIX - 1);
    localparam logic [2:0]  S_RESET = S_CLEAR;
`else
    localparam logic [2:0]  S_RESET = S_IDLE;
`endif

    logic [2:0]  state;
    logic [7:0]  rx;
    logic [6:0]  ry;
    logic        clearing;
    logic        in_range;
    logic        plot_ok;
    logic        plot_bad;
    logic        rd_issue;
    logic        rd_last;
    logic [14:0] plot_addr;
    logic [14:0] scan_addr;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [2:0]  ram_wdata;
    logic [2:0]  rd_q;
    logic [2:0]  fb [NPIX];
`ifdef PLOT_SINK_CLEAR_EN
    logic [14:0] clr_addr;
    assign clearing = (state == S_CLEAR);
`else
    assign clearing = 1'b0;
`endif

    // Plot qualification and raster read decode.
    assign in_range  = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
    assign plot_ok   = vga_plot && in_range && !clearing;
    assign plot_bad  = vga_plot && !plot_ok;
    assign rd_issue  = (state == S_SCAN) && !vga_plot;
    assign rd_last   = rd_issue && (rx == X_LAST) && (ry == Y_LAST);
    assign plot_addr = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);
    assign scan_addr = 15'(ry) * 15'(WIDTH) + 15'(rx);
    assign scanning  = (state == S_SCAN) || (state == S_DRAIN);
    assign pix_colour = pix_valid ? rd_q : 3'd0;

    // RAM port arbitration: plot first, then clear sweep, otherwise scan read.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        ram_we    = plot_ok;
        ram_addr  = plot_addr;
        ram_wdata = vga_colour;
        if (!plot_ok) begin
`ifdef PLOT_SINK_CLEAR_EN
            if (clearing) begin
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_wdata = 3'd0;
            end else begin
                ram_addr  = scan_addr;
            end
`else
            ram_addr = scan_addr;
`endif
        end
    end

    // Single-port synchronous framebuffer with a registered read.
    // NOTE: the array is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we)
            fb[ram_addr] <= ram_wdata;
        rd_q <= fb[ram_addr];
    end

    // Control FSM and raster counters.
    // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
            rx    <= 8'd0;
            ry    <= 7'd0;
`ifdef PLOT_SINK_CLEAR_EN
            clr_addr <= 15'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef PLOT_SINK_CLEAR_EN
                    if (clear) begin
                        state    <= S_CLEAR;
                        clr_addr <= 15'd0;
                    end else
`endif
                    if (start_scan) begin
                        state <= S_SCAN;
                        rx    <= 8'd0;
                        ry    <= 7'd0;
                    end
                end
                S_SCAN: begin
                    if (rd_issue) begin
                        if (rx == X_LAST) begin
                            rx <= 8'd0;
                            if (ry == Y_LAST)
                                state <= S_DRAIN;
                            else
                                ry <= ry + 7'd1;
                        end else begin
                            rx <= rx + 8'd1;
                        end
                    end
                end
                S_DRAIN: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
`ifdef PLOT_SINK_CLEAR_EN
                S_CLEAR: begin
                    clr_addr <= clr_addr + 15'd1;
                    if (clr_addr == A_LAST)
                        state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Readback outputs, one cycle behind the issued read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            scan_done <= 1'b0;
            pix_x     <= 8'd0;
            pix_y     <= 7'd0;
        end else begin
            pix_valid <= rd_issue;
            scan_done <= rd_last;
            if (rd_issue) begin
                pix_x <= rx;
                pix_y <= ry;
            end
        end
    end

    // Saturating plot statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plot_count <= 15'd0;
            oob_count  <= 8'd0;
        end else begin
            if (plot_ok && (plot_count != 15'h7fff))
                plot_count <= plot_count + 15'd1;
            if (plot_bad && (oob_count != 8'hff))
                oob_count <= oob_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: directed sequence with randomized plot
// traffic, compared against a frame-array model of the pixel store.
`timescale 1ns/1ps
module tb_plot_sink;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst;
`ifdef PLOT_SINK_CLEAR_EN
    logic        clear;
`endif
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        start_scan;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  pix_colour;
    logic        pix_valid;
    logic        scan_done;
    logic        scanning;
    logic [14:0] plot_count;
    logic [7:0]  oob_count;

    always #5 clk = ~clk;

    plot_sink #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PLOT_SINK_CLEAR_EN
        .clear      (clear),
`endif
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .start_scan (start_scan),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_valid  (pix_valid),
        .scan_done  (scan_done),
        .scanning   (scanning),
        .plot_count (plot_count),
        .oob_count  (oob_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int model_fb [NPIX];   // -1 = contents unknown
    int exp_plot = 0;
    int exp_oob  = 0;
    int pix_idx  = 0;
    int seen_57  = -1;
    int last_colour = -1;
    bit clear_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge pass, then compare outputs.
    task automatic cycle(input bit plot, input int x, input int y, input int col, input bit start);
        vga_plot   = plot;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(col);
        start_scan = start;
        @(posedge clk);
        @(negedge clk);
        if (pix_valid === 1'b1) begin
            if (pix_idx >= NPIX) begin
                check("extra_pixel", pix_idx, NPIX - 1);
            end else begin
                check("pix_x", pix_x, pix_idx % W);
                check("pix_y", pix_y, pix_idx / W);
                if (model_fb[pix_idx] >= 0)
                    check("pix_colour", pix_colour, model_fb[pix_idx]);
                if (pix_x == 8'd5 && pix_y == 7'd7)
                    seen_57 = int'(pix_colour);
                if (scan_done === 1'b1)
                    last_colour = int'(pix_colour);
            end
            pix_idx++;
        end
        if (plot) begin
            if (x < W && y < H && !clear_busy) begin
                model_fb[y * W + x] = col;
                if (exp_plot < 32767) exp_plot++;
            end else if (exp_oob < 255) begin
                exp_oob++;
            end
        end
        check("plot_count", plot_count, exp_plot);
        check("oob_count", oob_count, exp_oob);
    endtask

    // Full raster readback. mode 0: quiet; 1: 10-cycle burst at (159,119,6);
    // 2: random plots and stray start pulses. stop_at >= 0 returns early.
    task automatic scan(input int mode, input int stop_at);
        int issued, exp_done, done_cyc, px, py, pc;
        bit pl, st;
        pix_idx  = 0;
        issued   = 0;
        exp_done = -1;
        done_cyc = -1;
        for (int c = 0; c < 30000; c++) begin
            pl = 1'b0; px = 0; py = 0; pc = 0;
            st = (c == 0);
            if (mode == 1 && c >= 100 && c < 110) begin
                pl = 1'b1; px = 159; py = 119; pc = 6;
            end else if (mode == 2) begin
                pl = ($urandom_range(0, 15) == 0);
                px = $urandom_range(0, 170);
                py = $urandom_range(0, 125);
                pc = $urandom_range(0, 7);
                if (c > 0) st = ($urandom_range(0, 63) == 0);
            end
            if (c >= 1 && issued < NPIX && !pl) begin
                issued++;
                if (issued == NPIX) exp_done = c + 1;
            end
            cycle(pl, px, py, pc, st);
            if (c == 0) check("scanning_on", scanning, 1);
            if (stop_at >= 0 && pix_idx >= stop_at) return;
            if (scan_done === 1'b1) begin
                done_cyc = c + 1;
                check("done_with_valid", pix_valid, 1);
                check("done_pix_count", pix_idx, NPIX);
                check("scanning_drain", scanning, 1);
                break;
            end
        end
        check("done_cycle", done_cyc, exp_done);
        if (mode == 0) check("done_cycle_quiet", done_cyc, 19201);
        if (mode == 1) check("done_cycle_stall", done_cyc, 19211);
        cycle(1'b0, 0, 0, 0, 1'b0);
        check("scanning_off", scanning, 0);
        check("done_pulse_one", scan_done, 0);
        cycle(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic fill(input bit all_seven);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                cycle(1'b1, x, y, all_seven ? 7 : x % 8, 1'b0);
    endtask

    // After reset exit the clear build sweeps the frame to zero first.
    task automatic settle_after_reset();
`ifdef PLOT_SINK_CLEAR_EN
        for (int i = 0; i < NPIX; i++) model_fb[i] = 0;
        clear_busy = 1'b1;
        for (int i = 0; i < NPIX + 10; i++) cycle(1'b0, 0, 0, 0, 1'b0);
        clear_busy = 1'b0;
`endif
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) model_fb[i] = -1;
        rst = 1'b1;
`ifdef PLOT_SINK_CLEAR_EN
        clear = 1'b0;
`endif
        vga_plot = 1'b0; vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd0; start_scan = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_pix_colour", pix_colour, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_scanning", scanning, 0);
        check("rst_plot_count", plot_count, 0);
        check("rst_oob_count", oob_count, 0);
        rst = 1'b0;
        settle_after_reset();

        // Out-of-range plots on both edges.
        cycle(1'b1, 160, 0, 5, 1'b0);
        cycle(1'b1, 0, 120, 2, 1'b0);
        check("oob_two", oob_count, 2);
        check("plot_zero", plot_count, 0);

        // Single plot then a quiet scan.
        cycle(1'b1, 5, 7, 3, 1'b0);
        scan(0, -1);
        check("pix_5_7", seen_57, 3);
        check("plot_one", plot_count, 1);

        // Fill-screen stream, then a scan with a 10-cycle plot burst.
        fill(1'b0);
        check("plot_after_fill", plot_count, 19201);
        scan(1, -1);
        check("last_pix_colour", last_colour, 6);

        // Reset in the middle of a scan.
        scan(0, 500);
        vga_plot = 1'b0; start_scan = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_scanning", scanning, 0);
        check("midrst_plot_count", plot_count, 0);
        check("midrst_oob_count", oob_count, 0);
        check("midrst_pix_x", pix_x, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_plot = 0;
        exp_oob  = 0;
        settle_after_reset();

        // Saturate the reject counter, then mixed random traffic.
        for (int i = 0; i < 260; i++)
            cycle(1'b1, 160 + $urandom_range(0, 95), $urandom_range(0, 127), $urandom_range(0, 7), 1'b0);
        check("oob_saturated", oob_count, 255);
        for (int i = 0; i < 140; i++)
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 175), $urandom_range(0, 127),
                  $urandom_range(0, 7), 1'b0);

        // Scan with random interleaved plots; earlier data must survive the reset.
        scan(2, -1);

`ifdef PLOT_SINK_CLEAR_EN
        fill(1'b1);
        clear = 1'b1;
        cycle(1'b0, 0, 0, 0, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < NPIX; i++) model_fb[i] = 0;
        clear_busy = 1'b1;
        for (int i = 0; i < NPIX + 1; i++) begin
            cycle(i == 5, 3, 3, 5, 1'b0);
            if (i == 5) check("clear_not_scanning", scanning, 0);
        end
        clear_busy = 1'b0;
        scan(0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
